// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half adders plus an OR)
// processes one bit per clock, LSB first, behind a Start/Busy/Done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [WIDTH-2:0]   psum;
  logic               carry;
  logic               s0, c0, s1, c1;
  logic               carry_next;
  logic [WIDTH-1:0]   psum_full;
  logic               accept, last_bit;

  ha u_ha0 (.A(a_sh[0]), .B(b_sh[0]), .Sum(s0), .Cout(c0));
  ha u_ha1 (.A(s0),      .B(carry),   .Sum(s1), .Cout(c1));

  assign carry_next = c0 | c1;
  // Newest sum bit on top of the bits collected so far; complete on the last edge.
  assign psum_full  = {s1, psum};

  assign accept   = Start && (state == IDLE || state == DONE);
  assign last_bit = (state == ADD) && (count == CNT_W'(WIDTH - 1));

  assign Busy = (state == ADD);
  assign Done = (state == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = ADD;
      ADD:     if (last_bit) state_next = DONE;
      DONE:    state_next = Start ? ADD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      count <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= Cin;
      count <= '0;
    end else if (state == ADD) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      psum  <= psum_full[WIDTH-1:1];
      carry <= carry_next;
      count <= count + 1'b1;
      if (last_bit) begin
        Sum  <= psum_full;
        Cout <= carry_next;
      end
    end
  end

endmodule

// Half adder used as the building block of the serial full-adder slice.
module ha (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B;
  assign Cout = A & B;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder (WIDTH=8): reset, latency,
// carry chains, ignored Start during ADD, back-to-back ops and reset abort.
module tb_serial_adder;

  logic       Clk = 1'b0;
  logic       Reset, Start, Cin;
  logic [7:0] A, B;
  logic       Busy, Done, Cout;
  logic [7:0] Sum;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_sum = 8'h00;
  logic       last_cout = 1'b0;
  logic       mon_en = 1'b0;

  always #5 Clk = ~Clk;

  serial_adder #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Busy and Done must never be high together.
  always @(negedge Clk) begin
    if (mon_en) check("busy_done_exclusive", {31'd0, Busy & Done}, 32'd0);
  end

  // Starts an op from the current (IDLE or DONE) cycle, scrambles inputs while
  // busy, and returns sampled in the Done cycle with Start low.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input string name);
    int n, busy_n;
    A = a; B = b; Cin = cin; Start = 1'b1;
    tick();
    n = 0; busy_n = 0;
    while (Done !== 1'b1 && n < 20) begin
      if (Busy === 1'b1) busy_n++;
      if (n == 3) begin
        check({name, " sum_hold_busy"}, {24'd0, Sum}, {24'd0, last_sum});
        check({name, " cout_hold_busy"}, {31'd0, Cout}, {31'd0, last_cout});
      end
      A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom); Start = 1'($urandom);
      tick();
      n++;
    end
    Start = 1'b0;
    check({name, " latency"}, n, 8);
    check({name, " busy_cycles"}, busy_n, 8);
    check({name, " sum"}, {24'd0, Sum}, {24'd0, es});
    check({name, " cout"}, {31'd0, Cout}, {31'd0, ec});
    last_sum = es;
    last_cout = ec;
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_01"};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_c"};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "00_00_c"};
    vecs[3] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, "55_aa"};
    vecs[4] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_c"};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "7f_01"};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, "80_7f_c"};
    vecs[7] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "3c_0f"};

    // Reset held two edges with Start high
    Reset = 1'b1; Start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    check("rst busy", {31'd0, Busy}, 32'd0);
    check("rst done", {31'd0, Done}, 32'd0);
    check("rst sum", {24'd0, Sum}, 32'd0);
    check("rst cout", {31'd0, Cout}, 32'd0);
    Reset = 1'b0; Start = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_after_rst busy", {31'd0, Busy}, 32'd0);
    end

    // Basic op and result hold afterwards
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "0f_01");
    tick();
    check("post_done done", {31'd0, Done}, 32'd0);
    check("post_done busy", {31'd0, Busy}, 32'd0);
    tick();
    check("idle sum_hold", {24'd0, Sum}, 32'h10);
    check("idle cout_hold", {31'd0, Cout}, 32'd0);

    foreach (vecs[i]) begin
      tick();
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].name);
    end

    // Back-to-back: second op accepted in the Done cycle of the first
    tick();
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "12_34");
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "b2b 80_80");
    tick();
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "pre_abort");
    tick();

    // Reset after the 4th ADD edge aborts the op
    begin
      int done_seen;
      A = 8'h55; B = 8'h55; Cin = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("abort busy_before", {31'd0, Busy}, 32'd1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("abort busy", {31'd0, Busy}, 32'd0);
      check("abort done", {31'd0, Done}, 32'd0);
      check("abort sum", {24'd0, Sum}, 32'd0);
      check("abort cout", {31'd0, Cout}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (Done === 1'b1) done_seen++;
      end
      check("abort no_done", done_seen, 0);
      last_sum = 8'h00;
      last_cout = 1'b0;
    end

    // Random operations with random idle spacing
    for (int k = 0; k < 200; k++) begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] total;
      int         gap;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      total = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      run_op(ra, rb, rc, total[7:0], total[8], "rand");
    end

    tick();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
